// File: rtl/packet_receiver_if.sv
// Packet receiver bus: the byte stream from uart_rx_8n1 going in, and the
// assembled packet with its valid/ack handshake and status flags coming out.
//   rx_byte[7:0]      byte from uart_rx_8n1 .data
//   rx_ready          uart_rx_8n1 .ready (level; a rising edge means a new byte)
//   packet[8*PS-1:0]  assembled packet; the first byte is in the MSB byte
//   packet_valid      packet holds an unacknowledged complete packet
//   packet_ack        consumer takes the packet
//   overrun           1-clk pulse: a completed packet was dropped
//   timeout_err       1-clk pulse: a partial packet was discarded
//   busy              a partial packet is being collected
// master: byte source plus consumer. slave: the receiver.
interface packet_receiver_if #(
  parameter int unsigned PACKET_SIZE = 15
);
  logic [7:0]               rx_byte;
  logic                     rx_ready;
  logic [8*PACKET_SIZE-1:0] packet;
  logic                     packet_valid;
  logic                     packet_ack;
  logic                     overrun;
  logic                     timeout_err;
  logic                     busy;

  modport master (
    output rx_byte, rx_ready, packet_ack,
    input  packet, packet_valid, overrun, timeout_err, busy
  );

  modport slave (
    input  rx_byte, rx_ready, packet_ack,
    output packet, packet_valid, overrun, timeout_err, busy
  );
endinterface

// File: rtl/packet_receiver.sv
// packet_receiver: collects PACKET_SIZE bytes from uart_rx_8n1 into one
// parallel packet. The first byte received lands in the MSB byte. The packet
// is presented with a valid/ack handshake. The output register is separate
// from the shift register, so the next packet can be collected while the
// current one is still held. An inter-byte timeout discards a partial packet.
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  packet_receiver_if.slave (see the interface for the signal list)
module packet_receiver #(
  parameter int unsigned PACKET_SIZE    = 15,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              rst,
  packet_receiver_if.slave  bus
);
  localparam int unsigned      PW   = 8 * PACKET_SIZE;
  localparam int unsigned      CW   = $clog2(PACKET_SIZE + 1);
  localparam logic [CW-1:0]    LAST = CW'(PACKET_SIZE - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPLETE} state_t;

  state_t          state;
  logic            rx_ready_q;
  logic [PW-1:0]   shift;
  logic [PW-1:0]   packet_q;
  logic [CW-1:0]   count;
  logic [31:0]     tmo_cnt;
  logic            valid_q;
  logic            overrun_q;
  logic            tmo_err_q;

  logic            strobe;
  logic            tmo_hit;

  // A byte is accepted only on the rising edge of rx_ready.
  assign strobe  = bus.rx_ready & ~rx_ready_q;
  // A byte arriving in the same cycle as the timeout takes priority.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (count != '0) &&
                   (tmo_cnt >= TIMEOUT_CYCLES) && !strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready_q <= 1'b0;
      shift      <= '0;
      packet_q   <= '0;
      count      <= '0;
      tmo_cnt    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      rx_ready_q <= bus.rx_ready;
      overrun_q  <= 1'b0;
      tmo_err_q  <= 1'b0;

      if (valid_q && bus.packet_ack)
        valid_q <= 1'b0;

      if (strobe || count == '0)
        tmo_cnt <= '0;
      else if (tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 32'd1;

      // The completion step reads the shift register before a byte that
      // arrives in the same cycle shifts in, so that byte starts a new packet.
      if (state == COMPLETE) begin
        if (!valid_q || bus.packet_ack) begin
          packet_q <= shift;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state)
        IDLE, COMPLETE: begin
          if (strobe) begin
            shift <= (shift << 8) | PW'(bus.rx_byte);
            if (count == LAST) begin
              count <= '0;
              state <= COMPLETE;
            end else begin
              count <= count + 1'b1;
              state <= COLLECT;
            end
          end else begin
            state <= IDLE;
          end
        end
        COLLECT: begin
          if (tmo_hit) begin
            count     <= '0;
            shift     <= '0;
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b1;
            state     <= IDLE;
          end else if (strobe) begin
            shift <= (shift << 8) | PW'(bus.rx_byte);
            if (count == LAST) begin
              count <= '0;
              state <= COMPLETE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.packet       = packet_q;
  assign bus.packet_valid = valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = tmo_err_q;
  assign bus.busy         = (count != '0);
endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;
  localparam int unsigned PS = 15;
  localparam int unsigned PW = 8 * PS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_receiver_if #(.PACKET_SIZE(PS)) bus_if();

  packet_receiver #(
    .PACKET_SIZE(PS),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [PW-1:0] exp_q[$];
  int unsigned exp_ovr = 0, exp_tmo = 0, seen_ovr = 0, seen_tmo = 0;
  logic prev_valid = 1'b0;
  logic prev_ack   = 1'b0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // Monitor: a new packet is presented when valid rises, or when valid stays
  // high across a cycle in which ack was given (reload in the ack cycle).
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (bus_if.overrun)     seen_ovr++;
      if (bus_if.timeout_err) seen_tmo++;
      if (bus_if.packet_valid && (!prev_valid || prev_ack)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_packet: got %0h required none", bus_if.packet);
        end else begin
          check("packet", bus_if.packet, exp_q.pop_front());
        end
      end
      prev_valid = bus_if.packet_valid;
      prev_ack   = bus_if.packet_ack;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus_if.rx_byte  = b;
    bus_if.rx_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.rx_ready = 1'b0;
  endtask

  task automatic send_pkt(input logic [PW-1:0] p);
    for (int i = 0; i < int'(PS); i++)
      send_byte(p[PW-1-8*i -: 8]);
  endtask

  task automatic ack_pkt();
    @(posedge clk); #1;
    bus_if.packet_ack = 1'b1;
    @(posedge clk); #1;
    bus_if.packet_ack = 1'b0;
  endtask

  function automatic logic [PW-1:0] ramp(input logic [7:0] first);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(PS); i++)
      p = (p << 8) | PW'(first + 8'(i));
    return p;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_packet"},  bus_if.packet, '0);
    check({tag, "_valid"},   PW'(bus_if.packet_valid), '0);
    check({tag, "_busy"},    PW'(bus_if.busy), '0);
    check({tag, "_overrun"}, PW'(bus_if.overrun), '0);
    check({tag, "_timeout"}, PW'(bus_if.timeout_err), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] t1, p, a, b, c, d, e, f;
    t1 = "this is a test ";

    bus_if.rx_byte    = '0;
    bus_if.rx_ready   = 1'b0;
    bus_if.packet_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: text packet
    exp_q.push_back(t1);
    send_pkt(t1);
    @(negedge clk);
    check("t1_busy", PW'(bus_if.busy), '0);
    @(negedge clk);
    check("t1_valid", PW'(bus_if.packet_valid), PW'(1));
    ack_pkt();
    @(negedge clk);
    check("t1_valid_after_ack", PW'(bus_if.packet_valid), '0);

    // T2: byte order and 1-clk latency
    p = ramp(8'h01);
    exp_q.push_back(p);
    send_pkt(p);
    @(negedge clk);
    check("t2_valid_early", PW'(bus_if.packet_valid), '0);
    @(negedge clk);
    check("t2_valid", PW'(bus_if.packet_valid), PW'(1));
    check("t2_first_byte", PW'(bus_if.packet[PW-1 -: 8]), PW'(8'h01));
    check("t2_last_byte", PW'(bus_if.packet[7:0]), PW'(8'h0F));
    ack_pkt();

    // T3: level held for 5 clks counts once
    p = (ramp(8'h30) & ~({8'hFF, {(PW-8){1'b0}}})) | {8'hAA, {(PW-8){1'b0}}};
    exp_q.push_back(p);
    @(posedge clk); #1;
    bus_if.rx_byte  = 8'hAA;
    bus_if.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus_if.rx_ready = 1'b0;
    @(negedge clk);
    check("t3_busy", PW'(bus_if.busy), PW'(1));
    for (int i = 1; i < int'(PS); i++)
      send_byte(p[PW-1-8*i -: 8]);
    repeat (2) @(negedge clk);
    check("t3_valid", PW'(bus_if.packet_valid), PW'(1));
    ack_pkt();

    // T4: overrun, then reload in the ack cycle
    a = ramp(8'h40);
    b = ramp(8'h60);
    c = ramp(8'h80);
    exp_q.push_back(a);
    send_pkt(a);
    repeat (2) @(negedge clk);
    exp_ovr++;
    send_pkt(b);
    repeat (3) @(negedge clk);
    check("t4_packet_kept", bus_if.packet, a);
    check("t4_valid_kept", PW'(bus_if.packet_valid), PW'(1));
    check("t4_overrun_seen", PW'(seen_ovr), PW'(1));
    exp_q.push_back(c);
    send_pkt(c);
    bus_if.packet_ack = 1'b1;
    @(posedge clk); #1;
    bus_if.packet_ack = 1'b0;
    @(negedge clk);
    check("t4_valid_stays", PW'(bus_if.packet_valid), PW'(1));
    check("t4_packet_c", bus_if.packet, c);
    @(negedge clk);
    check("t4_no_overrun", PW'(seen_ovr), PW'(1));

    // T6: reset mid-packet with the output held
    d = ramp(8'hA0);
    for (int i = 0; i < 7; i++)
      send_byte(d[PW-1-8*i -: 8]);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_async");
    @(posedge clk); #1;
    rst = 1'b0;
    e = ramp(8'hC0);
    exp_q.push_back(e);
    send_pkt(e);
    repeat (2) @(negedge clk);
    check("t6_packet", bus_if.packet, e);
    ack_pkt();

    // T5: timeout after 3 bytes, then a clean packet
    f = ramp(8'hE0);
    for (int i = 0; i < 3; i++)
      send_byte(8'h11);
    exp_tmo++;
    repeat (50) @(negedge clk);
    check("t5_busy_before", PW'(bus_if.busy), PW'(1));
    repeat (60) @(negedge clk);
    check("t5_busy_after", PW'(bus_if.busy), '0);
    check("t5_timeout_seen", PW'(seen_tmo), PW'(1));
    exp_q.push_back(f);
    send_pkt(f);
    repeat (2) @(negedge clk);
    check("t5_packet", bus_if.packet, f);
    ack_pkt();

    repeat (5) @(negedge clk);
    check("queue_drained", PW'(exp_q.size()), '0);
    check("overrun_cycles", PW'(seen_ovr), PW'(exp_ovr));
    check("timeout_cycles", PW'(seen_tmo), PW'(exp_tmo));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
